// File: rtl/seq_mult_unit.sv
// Multi-cycle 32x32->64 shift-and-add multiplier using the external 32-bit ADDER, one add per cycle.
// Optional feature macro: MULT_SIGNED_EN adds is_signed, a sign-fix state and one cycle of latency.
module seq_mult_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
`ifdef MULT_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;

`ifdef MULT_SIGNED_EN
  localparam logic [WIDTH-1:0]   WONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] PONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
  logic               neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_neg;

  // Magnitudes of signed operands; 0x80000000 maps onto itself, which is correct unsigned.
  assign mag_a    = (is_signed && op_a[WIDTH-1]) ? (~op_a + WONE) : op_a;
  assign mag_b    = (is_signed && op_b[WIDTH-1]) ? (~op_b + WONE) : op_b;
  assign prod_neg = ~{acc, mq} + PONE;
`endif

  // Adder operands come straight from the datapath registers.
  assign add_a   = acc;
  assign add_b   = mq[0] ? mcand : '0;
  assign add_cin = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
      cnt     <= '0;
`ifdef MULT_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef MULT_SIGNED_EN
            mcand <= mag_a;
            mq    <= mag_b;
            neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`else
            mcand <= op_a;
            mq    <= op_b;
`endif
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // Carry-out becomes the new MSB so no bit of the partial sum is lost.
          acc <= {add_cout, add_sum[WIDTH-1:1]};
          mq  <= {add_sum[0], mq[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) begin
`ifdef MULT_SIGNED_EN
            state <= FIX;
`else
            state <= DONE;
`endif
          end
        end
`ifdef MULT_SIGNED_EN
        FIX: begin
          if (neg) begin
            {acc, mq} <= prod_neg;
          end
          state <= DONE;
        end
`endif
        DONE: begin
          product <= {acc, mq};
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
